// File: rtl/inst_axi_bridge_pkg.sv
// Shared CPU bus definitions: AXI constants, SRAM size codes, bridge FSM states.
package inst_axi_bridge_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam int         INST_ARID      = 0;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic {
        AR_IDLE = 1'b0,
        AR_WAIT = 1'b1
    } ar_state_t;

endpackage

// File: rtl/inst_axi_bridge_if.sv
// Fetch SRAM-like port plus AXI AR/R channels; 'master' is the bridge view
// (drives AR and rready, serves fetch), 'slave' is the fetch/AXI-slave view.
interface inst_axi_bridge_if #(
    parameter int ID_W = 4
);
    logic            inst_sram_req;
    logic            inst_sram_wr;
    logic [1:0]      inst_sram_size;
    logic [31:0]     inst_sram_addr;
    logic            inst_sram_addr_ok;
    logic            inst_sram_data_ok;
    logic [31:0]     inst_sram_rdata;

    logic [ID_W-1:0] arid;
    logic [31:0]     araddr;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic [1:0]      arlock;
    logic [3:0]      arcache;
    logic [2:0]      arprot;
    logic            arvalid;
    logic            arready;

    logic [ID_W-1:0] rid;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready;

    modport master (
        input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_addr,
        output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_addr,
        input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/inst_axi_bridge.sv
// Instruction-side bridge: fetch SRAM-like reads to single-beat AXI4 reads,
// in-order returns, up to MAX_OUTSTANDING reads in flight.
module inst_axi_bridge
    import inst_axi_bridge_pkg::*;
#(
    parameter int ID_W            = 4,
    parameter int ARID_VAL        = INST_ARID,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    inst_axi_bridge_if.master         bus
);

    localparam int              CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    ar_state_t         r_ar_state, w_ar_state_nxt;
    logic [31:0]       r_ar_addr,  w_ar_addr_nxt;
    logic [2:0]        r_ar_size,  w_ar_size_nxt;
    logic [CNT_W-1:0]  r_cnt,      w_cnt_nxt;

    logic              w_accept;
    logic              w_data_ok;
    logic              w_ar_pending_only;
    logic              w_rready;
    logic              w_unused;

    // Write flag, ID, last and response are don't-cares on the instruction side.
    assign w_unused = ^{bus.inst_sram_wr, bus.rid, bus.rresp, bus.rlast};

    assign w_accept = bus.inst_sram_req
                    && ((r_ar_state == AR_IDLE) || bus.arready)
                    && (r_cnt < MAX_CNT);

    // A lone read still sitting in AR is not owed an R beat yet.
    assign w_ar_pending_only = (r_cnt == ONE_CNT) && (r_ar_state == AR_WAIT);
    assign w_rready          = (r_cnt != '0) && !w_ar_pending_only;
    assign w_data_ok         = bus.rvalid && w_rready;

    assign bus.inst_sram_addr_ok = w_accept;
    assign bus.inst_sram_data_ok = w_data_ok;
    assign bus.inst_sram_rdata   = bus.rdata;
    assign bus.rready            = w_rready;

    assign bus.arid    = ID_W'(ARID_VAL);
    assign bus.araddr  = r_ar_addr;
    assign bus.arlen   = '0;
    assign bus.arsize  = r_ar_size;
    assign bus.arburst = AXI_BURST_INCR;
    assign bus.arlock  = '0;
    assign bus.arcache = '0;
    assign bus.arprot  = '0;
    assign bus.arvalid = (r_ar_state == AR_WAIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ar_state <= AR_IDLE;
            r_ar_addr  <= '0;
            r_ar_size  <= '0;
            r_cnt      <= '0;
        end else begin
            r_ar_state <= w_ar_state_nxt;
            r_ar_addr  <= w_ar_addr_nxt;
            r_ar_size  <= w_ar_size_nxt;
            r_cnt      <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_ar_state_nxt = r_ar_state;
        w_ar_addr_nxt  = r_ar_addr;
        w_ar_size_nxt  = r_ar_size;
        w_cnt_nxt      = r_cnt;

        // Acceptance implies the slot is free or draining this cycle,
        // so a new load takes priority over the arready return to idle.
        unique case (r_ar_state)
            AR_IDLE: if (w_accept) w_ar_state_nxt = AR_WAIT;
            AR_WAIT: if (!w_accept && bus.arready) w_ar_state_nxt = AR_IDLE;
            default: w_ar_state_nxt = AR_IDLE;
        endcase

        if (w_accept) begin
            w_ar_addr_nxt = bus.inst_sram_addr;
            w_ar_size_nxt = {1'b0, bus.inst_sram_size};
        end

        unique case ({w_accept, w_data_ok})
            2'b10:   w_cnt_nxt = r_cnt + ONE_CNT;
            2'b01:   w_cnt_nxt = r_cnt - ONE_CNT;
            default: w_cnt_nxt = r_cnt;
        endcase
    end

endmodule

// File: tb/tb_inst_axi_bridge.sv
// Directed bench for inst_axi_bridge: reset, single read, AR back-pressure,
// outstanding limit, accept+return overlap, error response, mid-flight reset.
module tb_inst_axi_bridge;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    inst_axi_bridge_if #(.ID_W(4)) bus ();

    inst_axi_bridge #(
        .ID_W            (4),
        .ARID_VAL        (0),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks run 2 units later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_in();
        bus.inst_sram_req  = 1'b0;
        bus.inst_sram_wr   = 1'b0;
        bus.inst_sram_size = 2'd2;
        bus.inst_sram_addr = 32'h0;
        bus.arready        = 1'b0;
        bus.rid            = 4'h0;
        bus.rdata          = 32'h0;
        bus.rresp          = 2'b00;
        bus.rlast          = 1'b1;
        bus.rvalid         = 1'b0;
    endtask

    task automatic req(input logic [31:0] a, input logic [1:0] sz);
        bus.inst_sram_req  = 1'b1;
        bus.inst_sram_addr = a;
        bus.inst_sram_size = sz;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        idle_in();
        cyc();
        cyc();
        settle();
        chk("rst_arvalid", bus.arvalid, 0);
        chk("rst_rready",  bus.rready, 0);
        chk("rst_addr_ok", bus.inst_sram_addr_ok, 0);
        chk("rst_data_ok", bus.inst_sram_data_ok, 0);
        chk("rst_araddr",  bus.araddr, 32'h0);
        reset = 1'b0;
        cyc();

        // Single read
        req(32'h1c00_0000, 2'd2); bus.arready = 1'b1; settle();
        chk("s_addr_ok", bus.inst_sram_addr_ok, 1);
        cyc();
        bus.inst_sram_req = 1'b0; settle();
        chk("s_arvalid", bus.arvalid, 1);
        chk("s_araddr",  bus.araddr, 32'h1c00_0000);
        chk("s_arsize",  bus.arsize, 3'b010);
        chk("s_arlen",   bus.arlen, 0);
        chk("s_arburst", bus.arburst, 2'b01);
        chk("s_arid",    bus.arid, 0);
        chk("s_rready_ar_pending", bus.rready, 0);
        cyc();
        settle();
        chk("s_arvalid_drop", bus.arvalid, 0);
        chk("s_rready", bus.rready, 1);
        chk("s_no_data", bus.inst_sram_data_ok, 0);
        cyc();
        bus.rvalid = 1'b1; bus.rdata = 32'h0280_0000; settle();
        chk("s_data_ok", bus.inst_sram_data_ok, 1);
        chk("s_rdata",   bus.inst_sram_rdata, 32'h0280_0000);
        cyc();
        bus.rdata = 32'h5555_5555; settle();
        chk("s_cnt0_rready",  bus.rready, 0);
        chk("s_cnt0_data_ok", bus.inst_sram_data_ok, 0);
        cyc();
        idle_in();

        // AR back-pressure
        req(32'h1c00_0010, 2'd1); settle();
        chk("bp_addr_ok0", bus.inst_sram_addr_ok, 1);
        cyc();
        req(32'h1c00_0014, 2'd2); settle();
        chk("bp_arsize_h", bus.arsize, 3'b001);
        for (int i = 0; i < 3; i++) begin
            chk("bp_arvalid_hold", bus.arvalid, 1);
            chk("bp_araddr_hold",  bus.araddr, 32'h1c00_0010);
            chk("bp_addr_ok_blk",  bus.inst_sram_addr_ok, 0);
            cyc();
            settle();
        end
        bus.arready = 1'b1; settle();
        chk("bp_addr_ok_hs", bus.inst_sram_addr_ok, 1);
        chk("bp_araddr_hs",  bus.araddr, 32'h1c00_0010);
        cyc();
        bus.inst_sram_req = 1'b0; settle();
        chk("bp_arvalid2", bus.arvalid, 1);
        chk("bp_araddr2",  bus.araddr, 32'h1c00_0014);
        chk("bp_rready2",  bus.rready, 1);
        cyc();
        bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'h1111_1111; settle();
        chk("bp_data_ok1", bus.inst_sram_data_ok, 1);
        chk("bp_rdata1",   bus.inst_sram_rdata, 32'h1111_1111);
        cyc();
        bus.rdata = 32'h2222_2222; settle();
        chk("bp_data_ok2", bus.inst_sram_data_ok, 1);
        chk("bp_rdata2",   bus.inst_sram_rdata, 32'h2222_2222);
        cyc();
        idle_in(); settle();
        chk("bp_cnt0_rready", bus.rready, 0);
        cyc();

        // Outstanding limit
        bus.arready = 1'b1;
        req(32'h1c00_0000, 2'd2); settle();
        chk("lim_ok0", bus.inst_sram_addr_ok, 1);
        cyc();
        req(32'h1c00_0004, 2'd2); settle();
        chk("lim_ok1", bus.inst_sram_addr_ok, 1);
        cyc();
        req(32'h1c00_0008, 2'd2); settle();
        chk("lim_full0", bus.inst_sram_addr_ok, 0);
        chk("lim_araddr1", bus.araddr, 32'h1c00_0004);
        cyc();
        settle();
        chk("lim_full_slot_free", bus.inst_sram_addr_ok, 0);
        chk("lim_arvalid_idle",   bus.arvalid, 0);
        cyc();
        settle();
        chk("lim_full2", bus.inst_sram_addr_ok, 0);
        cyc();
        bus.rvalid = 1'b1; bus.rdata = 32'ha0a0_a0a0; settle();
        chk("lim_d0_ok",    bus.inst_sram_data_ok, 1);
        chk("lim_d0_rdata", bus.inst_sram_rdata, 32'ha0a0_a0a0);
        chk("lim_still_full", bus.inst_sram_addr_ok, 0);
        cyc();
        bus.rvalid = 1'b0; settle();
        chk("lim_ok2", bus.inst_sram_addr_ok, 1);
        cyc();
        bus.inst_sram_req = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'ha4a4_a4a4; settle();
        chk("lim_araddr2", bus.araddr, 32'h1c00_0008);
        chk("lim_d1_ok",    bus.inst_sram_data_ok, 1);
        chk("lim_d1_rdata", bus.inst_sram_rdata, 32'ha4a4_a4a4);
        cyc();
        bus.rdata = 32'ha8a8_a8a8; settle();
        chk("lim_d2_ok",    bus.inst_sram_data_ok, 1);
        chk("lim_d2_rdata", bus.inst_sram_rdata, 32'ha8a8_a8a8);
        cyc();
        bus.rvalid = 1'b0; settle();
        chk("lim_cnt0_rready", bus.rready, 0);
        cyc();

        // Accept and return in the same cycle
        req(32'h1c00_0004, 2'd2); settle();
        chk("sim_ok0", bus.inst_sram_addr_ok, 1);
        cyc();
        bus.inst_sram_req = 1'b0; settle();
        cyc();
        req(32'h1c00_0008, 2'd2); bus.rvalid = 1'b1; bus.rdata = 32'hb4b4_b4b4; settle();
        chk("sim_addr_ok", bus.inst_sram_addr_ok, 1);
        chk("sim_data_ok", bus.inst_sram_data_ok, 1);
        cyc();
        bus.inst_sram_req = 1'b0; bus.rvalid = 1'b0; settle();
        chk("sim_araddr",  bus.araddr, 32'h1c00_0008);
        chk("sim_arvalid", bus.arvalid, 1);
        chk("sim_cnt1_rready", bus.rready, 0);
        cyc();

        // Error response still returns data
        bus.rvalid = 1'b1; bus.rresp = 2'b10; bus.rdata = 32'hdead_beef; settle();
        chk("err_data_ok", bus.inst_sram_data_ok, 1);
        chk("err_rdata",   bus.inst_sram_rdata, 32'hdead_beef);
        cyc();
        idle_in(); settle();
        chk("err_cnt0_rready", bus.rready, 0);
        cyc();

        // Reset with two reads in flight
        bus.arready = 1'b1;
        req(32'h1c00_0020, 2'd2); settle();
        cyc();
        req(32'h1c00_0024, 2'd2); settle();
        chk("rm_ok1", bus.inst_sram_addr_ok, 1);
        cyc();
        bus.inst_sram_req = 1'b0; bus.arready = 1'b0; reset = 1'b1; settle();
        chk("rm_pre_arvalid", bus.arvalid, 1);
        chk("rm_pre_rready",  bus.rready, 1);
        cyc();
        reset = 1'b0; settle();
        chk("rm_arvalid", bus.arvalid, 0);
        chk("rm_rready",  bus.rready, 0);
        chk("rm_addr_ok", bus.inst_sram_addr_ok, 0);
        cyc();
        req(32'h1c00_0000, 2'd2); bus.arready = 1'b1; settle();
        chk("rm_post_ok", bus.inst_sram_addr_ok, 1);
        cyc();
        bus.inst_sram_req = 1'b0; settle();
        chk("rm_post_araddr", bus.araddr, 32'h1c00_0000);
        chk("rm_post_rready", bus.rready, 0);
        cyc();
        bus.rvalid = 1'b1; bus.rdata = 32'h1234_5678; settle();
        chk("rm_post_data_ok", bus.inst_sram_data_ok, 1);
        chk("rm_post_rdata",   bus.inst_sram_rdata, 32'h1234_5678);
        cyc();
        idle_in(); settle();
        chk("rm_post_cnt0", bus.rready, 0);
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/inst_axi_bridge.md
Name: inst_axi_bridge

Overview:
- Instruction-side bridge directly upstream of the fetch stage.
- Accepts the fetch stage's SRAM-like read requests (req / addr_ok / data_ok) and turns them into single-beat AXI4 read transactions (AR/R channels).
- Returns instruction words in request order.
- Tracks outstanding reads so fetch may issue a new address before earlier data returns, up to a fixed limit.

Parameters:
- ID_W, 4, width of arid/rid.
- ARID_VAL, 0, constant ID driven on arid (instruction side uses one ID, so responses arrive in order).
- MAX_OUTSTANDING, 2, maximum accepted-but-not-returned reads (AR pending plus awaiting R); range 1..7.

Ports:
- clk in 1 clock
- reset in 1 synchronous, active-high reset
- inst_sram_req in 1 fetch read request
- inst_sram_wr in 1 write flag; must be 0; ignored, always treated as read
- inst_sram_size in 2 0:1B 1:2B 2:4B
- inst_sram_addr in 32 byte address
- inst_sram_addr_ok out 1 request accepted this cycle
- inst_sram_data_ok out 1 instruction word valid this cycle
- inst_sram_rdata out 32 instruction word
- arid out ID_W
- araddr out 32
- arlen out 8
- arsize out 3
- arburst out 2
- arlock out 2
- arcache out 4
- arprot out 3
- arvalid out 1
- arready in 1
- rid in ID_W
- rdata in 32
- rresp in 2
- rlast in 1
- rvalid in 1
- rready out 1

Behaviour:
- Constant AR fields:
  - arid=ARID_VAL, arlen=0, arburst=2'b01, arlock=0, arcache=0, arprot=0.
  - arsize={1'b0, inst_sram_size}, captured with the address.
- AR holding register (ar_valid_r, ar_addr_r, ar_size_r):
  - States: AR_IDLE (ar_valid_r=0) and AR_WAIT (ar_valid_r=1).
  - arvalid=ar_valid_r; araddr/arsize come from the holding register.
  - AR_WAIT -> AR_IDLE on arready, unless a new request is accepted the same cycle, in which case it stays in AR_WAIT with the new address.
  - AR_IDLE -> AR_WAIT on acceptance.
  - While arvalid=1 and arready=0, araddr/arsize hold stable (AXI rule).
- Request acceptance (combinational):
  - accept = inst_sram_req && (!ar_valid_r || arready) && (cnt < MAX_OUTSTANDING).
  - inst_sram_addr_ok=accept.
  - Address is captured at the clock edge; arvalid rises the following cycle, so there is one cycle of request-to-AR latency.
- Outstanding counter cnt, width clog2(MAX_OUTSTANDING+1):
  - +1 on accept, -1 on data_ok.
  - Both in the same cycle: unchanged.
  - Never exceeds MAX_OUTSTANDING; never underflows, because rready=0 when cnt==0.
- R channel:
  - rready = (cnt != 0) && !ar_pending_only, where ar_pending_only means cnt==1 and that single read is still in AR_WAIT. This blocks beats not yet owed.
  - inst_sram_data_ok = rvalid && rready.
  - inst_sram_rdata = rdata, combinational pass-through; valid only when data_ok.
  - rid, rlast and rresp are ignored. A bus error still returns data_ok; fault handling is outside this block.
- Ordering: single ID, so data returns in acceptance order; there is no reorder buffer.
- Fetch cancellation: the fetch stage discards unwanted returns itself. The bridge never drops or cancels in-flight reads, and every accepted request yields exactly one data_ok.
- Reset values:
  - ar_valid_r=0, cnt=0, ar_addr_r=0, ar_size_r=0.
  - Hence arvalid=0, rready=0, addr_ok=0, data_ok=0.
  - Reset mid-transaction abandons all outstanding reads. The AXI slave shares the same reset.
- Full: with cnt==MAX_OUTSTANDING, addr_ok stays 0 even if the AR slot is free.
- Simultaneous accept + data_ok + arready in one cycle: all three take effect; cnt unchanged; the AR register loads the new request.

Decomposition:
- Shared header (existing CPU defines file) gains:
  - AXI_BURST_INCR=2'b01
  - AXI_RESP_OKAY=2'b00
  - INST_ARID=0
  - SRAM size codes SIZE_B/H/W = 0/1/2
- No sub-module is natural: a single module with the AR register and counter inline. The later data-side bridge reuses the same defines.

Test Plan:
- Single read: req addr=0x1c000000, arready=1, rvalid returns 2 cycles later with rdata=0x02800000 -> addr_ok in cycle 0; arvalid in cycle 1 with araddr=0x1c000000, arsize=3'b010; data_ok with rdata=0x02800000; cnt returns to 0.
- Back-pressure: arready=0 for 3 cycles -> arvalid and araddr held stable; second req gets addr_ok=0 until the AR handshake; then accepted in the same cycle as arready.
- Outstanding limit: MAX=2, continuous req at 0x1c000000/04/08, R delayed 5 cycles -> first two accepted, third held (addr_ok=0) until the first data_ok, then accepted; data returns in order.
- Simultaneous events: cnt=1, accept + data_ok + arready in the same cycle -> cnt stays 1; new araddr=0x1c000008 appears next cycle.
- Reset mid-operation: reset with cnt=2 and arvalid=1 -> next cycle arvalid=0, rready=0, addr_ok=0; the first post-reset req (0x1c000000) proceeds normally.
- Error response: rresp=2'b10 with rdata=0xdeadbeef -> data_ok=1, rdata=0xdeadbeef, cnt decrements.
